// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Purpose: arbitrates the single register-file write port between the ALU,
// a 2-entry buffer of load/IO return data and a debug/loader write port.
// It also keeps a busy scoreboard of registers with outstanding loads and
// raises a decode stall when a decode operand names one of them.
//
// Optional feature: define DEBUG_PORT_EN to build the debug write port and
// its age counter. Without it the dbg_* ports exist but are ignored and
// dbg_ack is tied low.
//
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   alu_we, alu_rd, alu_wdata        ALU writeback request (highest priority)
//   ld_valid, ld_ready, ld_rd,
//   ld_wdata                         load return handshake into the FIFO
//   issue_en, issue_rd               load issued; marks issue_rd busy
//   dec_rs1, dec_rs2, dec_rd         decode-stage register indices
//   stall                            decode hazard on a pending load
//   dbg_req, dbg_addr, dbg_wdata     debug/loader write request
//   dbg_ack                          debug write committed (1-cycle pulse)
//   rf_we, rf_waddr, rf_wdata        registered register-file write port
module regfile_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_we,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_wdata,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_wdata,
   input  logic        issue_en,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [4:0]  dec_rd,
   output logic        stall,
   input  logic        dbg_req,
   input  logic [4:0]  dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_ack,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
);

   // Load return FIFO storage
   logic [4:0]  fifoRd_q   [2];
   logic [31:0] fifoData_q [2];
   logic        head_q;
   logic [1:0]  count_q, count_d;
   logic        wrPtr;
   logic        push, pop;

   // Busy scoreboard
   logic [31:0] busy_q, busy_d;

   // Registered write port
   logic        rfWe_q;
   logic        rfIsLoad_q;
   logic [4:0]  rfAddr_q;
   logic [31:0] rfData_q;

   // Grant decision for this cycle
   logic        grantAny;
   logic        grantLoad;
   logic        grantDbg;
   logic [4:0]  grantRd;
   logic [31:0] grantData;
   logic        dbgPend;
   logic        dbgAged;

`ifdef DEBUG_PORT_EN
   logic [3:0]  age_q, age_d;
   logic        dbgArm_q, dbgArm_d;
   logic        dbgAck_q;

   // A request is only eligible once dbg_req has been seen low since the
   // last grant, so a held request is acknowledged exactly once.
   assign dbgPend = dbg_req & dbgArm_q;
   assign dbgAged = dbgPend & age_q[3];
   assign dbg_ack = dbgAck_q;

   // Age counts denied cycles of an eligible request; it restarts when the
   // request is granted or is no longer eligible.
   always_comb begin
      dbgArm_d = dbgArm_q;
      age_d    = age_q;
      if (!dbg_req) begin
         dbgArm_d = 1'b1;
      end else if (grantDbg) begin
         dbgArm_d = 1'b0;
      end
      if (grantDbg || !dbgPend) begin
         age_d = 4'd0;
      end else if (age_q != 4'hF) begin
         age_d = age_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         age_q    <= 4'd0;
         dbgArm_q <= 1'b1;
         dbgAck_q <= 1'b0;
      end else begin
         age_q    <= age_d;
         dbgArm_q <= dbgArm_d;
         dbgAck_q <= grantDbg;
      end
   end
`else
   logic unusedDbg;

   assign dbgPend   = 1'b0;
   assign dbgAged   = 1'b0;
   assign dbg_ack   = 1'b0;
   assign unusedDbg = ^{dbg_req, dbg_addr, dbg_wdata, grantDbg};
`endif

   // Priority: ALU, then a debug request that has waited long enough, then
   // the oldest buffered load, then a fresh debug request.
   always_comb begin
      grantAny  = 1'b0;
      grantLoad = 1'b0;
      grantDbg  = 1'b0;
      grantRd   = 5'd0;
      grantData = 32'd0;
      if (alu_we) begin
         grantAny  = 1'b1;
         grantRd   = alu_rd;
         grantData = alu_wdata;
      end else if (dbgAged) begin
         grantAny  = 1'b1;
         grantDbg  = 1'b1;
         grantRd   = dbg_addr;
         grantData = dbg_wdata;
      end else if (count_q != 2'd0) begin
         grantAny  = 1'b1;
         grantLoad = 1'b1;
         grantRd   = fifoRd_q[head_q];
         grantData = fifoData_q[head_q];
      end else if (dbgPend) begin
         grantAny  = 1'b1;
         grantDbg  = 1'b1;
         grantRd   = dbg_addr;
         grantData = dbg_wdata;
      end
   end

   // ld_ready is gated by rst so it reads low throughout reset.
   assign ld_ready = rst & (count_q != 2'd2);
   assign push     = ld_valid & ld_ready;
   assign pop      = grantLoad;
   assign wrPtr    = head_q ^ count_q[0];

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifoRd_q[0]   <= 5'd0;
         fifoRd_q[1]   <= 5'd0;
         fifoData_q[0] <= 32'd0;
         fifoData_q[1] <= 32'd0;
         head_q        <= 1'b0;
         count_q       <= 2'd0;
      end else begin
         if (push) begin
            fifoRd_q[wrPtr]   <= ld_rd;
            fifoData_q[wrPtr] <= ld_wdata;
         end
         if (pop) begin
            head_q <= ~head_q;
         end
         count_q <= count_d;
      end
   end

   // A load's busy bit clears when its write actually reaches the register
   // file; a new issue to the same register in that cycle keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (rfWe_q && rfIsLoad_q) begin
         busy_d[rfAddr_q] = 1'b0;
      end
      if (issue_en && (issue_rd != 5'd0)) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Writes to x0 are granted (popping or acking their source) but never
   // assert rf_we.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q     <= 32'd0;
         rfWe_q     <= 1'b0;
         rfIsLoad_q <= 1'b0;
         rfAddr_q   <= 5'd0;
         rfData_q   <= 32'd0;
      end else begin
         busy_q     <= busy_d;
         rfWe_q     <= grantAny && (grantRd != 5'd0);
         rfIsLoad_q <= grantLoad;
         if (grantAny) begin
            rfAddr_q <= grantRd;
            rfData_q <= grantData;
         end
      end
   end

   assign stall    = busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd];
   assign rf_we    = rfWe_q;
   assign rf_waddr = rfAddr_q;
   assign rf_wdata = rfData_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//
// Table-driven bench for regfile_wb_arbiter. Each vector drives one cycle of
// inputs, checks the combinational outputs (stall, ld_ready) in that cycle
// and queues the registered write-port values expected one cycle later,
// which are popped and compared after the next clock edge. Multi-cycle
// scenarios (FIFO backpressure, debug aging, mid-operation reset) are built
// as short hand-written sequences. Debug expectations follow DEBUG_PORT_EN.
module tb_regfile_wb_arbiter;

   localparam logic lo = 1'b0;
   localparam logic hi = 1'b1;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_we;
   logic [4:0]  alu_rd;
   logic [31:0] alu_wdata;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_wdata;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [4:0]  dec_rd;
   logic        stall;
   logic        dbg_req;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_ack;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_we(alu_we), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_wdata(ld_wdata),
      .issue_en(issue_en), .issue_rd(issue_rd),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .stall(stall),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   typedef struct {
      logic        aluWe;
      logic [4:0]  aluRd;
      logic [31:0] aluData;
      logic        ldValid;
      logic [4:0]  ldRd;
      logic [31:0] ldData;
      logic        issueEn;
      logic [4:0]  issueRd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rdD;
      logic        dbgReq;
      logic [4:0]  dbgAddr;
      logic [31:0] dbgData;
      logic        expStall;
      logic        expReady;
      logic        expWe;
      logic [4:0]  expAddr;
      logic [31:0] expData;
      logic        expAck;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        ack;
   } exp_t;

   exp_t expQ[$];
   vec_t tbl[$];
   int   vecCount  = 0;
   int   missCount = 0;

   function automatic vec_t mk(
      input logic aWe, input logic [4:0] aRd, input logic [31:0] aData,
      input logic lV, input logic [4:0] lRd, input logic [31:0] lData,
      input logic iEn, input logic [4:0] iRd,
      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] sd,
      input logic eStall, input logic eReady,
      input logic eWe, input logic [4:0] eAddr, input logic [31:0] eData);
      vec_t v;
      v.aluWe    = aWe;   v.aluRd   = aRd;   v.aluData = aData;
      v.ldValid  = lV;    v.ldRd    = lRd;   v.ldData  = lData;
      v.issueEn  = iEn;   v.issueRd = iRd;
      v.rs1      = s1;    v.rs2     = s2;    v.rdD     = sd;
      v.dbgReq   = 1'b0;  v.dbgAddr = 5'd0;  v.dbgData = 32'd0;
      v.expStall = eStall;
      v.expReady = eReady;
      v.expWe    = eWe;   v.expAddr = eAddr; v.expData = eData;
      v.expAck   = 1'b0;
      return v;
   endfunction

   // One comparison; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      vecCount++;
      if (act !== req) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      alu_we    = v.aluWe;   alu_rd   = v.aluRd;   alu_wdata = v.aluData;
      ld_valid  = v.ldValid; ld_rd    = v.ldRd;    ld_wdata  = v.ldData;
      issue_en  = v.issueEn; issue_rd = v.issueRd;
      dec_rs1   = v.rs1;     dec_rs2  = v.rs2;     dec_rd    = v.rdD;
      dbg_req   = v.dbgReq;  dbg_addr = v.dbgAddr; dbg_wdata = v.dbgData;
   endtask

   // Pop the oldest queued expectation and compare the registered outputs.
   task automatic checkWrite(input string tag);
      exp_t e;
      if (expQ.size() == 0) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL %s scoreboard: no expected entry queued", tag);
      end else begin
         e = expQ.pop_front();
         checkOutput({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, e.we});
         if (e.we) begin
            checkOutput({tag, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, e.addr});
            checkOutput({tag, " rf_wdata"}, rf_wdata, e.data);
         end
         checkOutput({tag, " dbg_ack"}, {31'd0, dbg_ack}, {31'd0, e.ack});
      end
   endtask

   // Called just after a rising edge: drive, check same-cycle outputs,
   // queue next-cycle expectation, clock, then compare.
   task automatic runVec(input vec_t v, input string tag);
      exp_t e;
      applyStimulus(v);
      #1;
      checkOutput({tag, " stall"}, {31'd0, stall}, {31'd0, v.expStall});
      checkOutput({tag, " ld_ready"}, {31'd0, ld_ready}, {31'd0, v.expReady});
      e.we   = v.expWe;
      e.addr = v.expAddr;
      e.data = v.expData;
      e.ack  = v.expAck;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      checkWrite(tag);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   ldIdx;

      rst = 1'b0;
      applyStimulus(mk(lo,5'd0,32'd0, lo,5'd0,32'd0, lo,5'd0, 5'd0,5'd0,5'd0, lo,lo, lo,5'd0,32'd0));

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset rf_we",    {31'd0, rf_we},    32'd0);
      checkOutput("reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
      checkOutput("reset rf_wdata", rf_wdata,          32'd0);
      checkOutput("reset dbg_ack",  {31'd0, dbg_ack},  32'd0);
      checkOutput("reset ld_ready", {31'd0, ld_ready}, 32'd0);
      checkOutput("reset stall",    {31'd0, stall},    32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // ALU write, load hazard and commit, set-over-clear, x0 suppression
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(hi,5'd5,32'h12345678,   lo,5'd0,32'd0,      lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, hi,5'd5,32'h12345678));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      hi,5'd7, 5'd7,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd7,5'd0,5'd0, hi,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          hi,5'd7,32'hFF,     lo,5'd0, 5'd7,5'd0,5'd0, hi,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd7,5'd0,5'd0, hi,hi, hi,5'd7,32'hFF));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd7,5'd0,5'd0, hi,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd7,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      hi,5'd9, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd0,5'd9,5'd0, hi,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd0,5'd0,5'd9, hi,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          hi,5'd9,32'hA5A5,   lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, hi,5'd9,32'hA5A5));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      hi,5'd9, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd9,5'd0,5'd0, hi,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          hi,5'd9,32'h1,      lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, hi,5'd9,32'h1));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd9,5'd0,5'd0, hi,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd9,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(hi,5'd0,32'hDEAD,       lo,5'd0,32'd0,      hi,5'd0, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          hi,5'd0,32'h77,     lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      tbl.push_back(mk(lo,5'd0,32'd0,          lo,5'd0,32'd0,      lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0));
      for (int i = 0; i < tbl.size(); i++) begin
         runVec(tbl[i], $sformatf("tbl%0d", i));
      end

      // FIFO backpressure while ALU holds the port, then in-order drain
      runVec(mk(hi,5'd10,32'h100, hi,5'd20,32'hB0, lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, hi,5'd10,32'h100), "fifo0");
      runVec(mk(hi,5'd11,32'h101, hi,5'd21,32'hB1, lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, hi,5'd11,32'h101), "fifo1");
      runVec(mk(hi,5'd12,32'h102, hi,5'd22,32'hB2, lo,5'd0, 5'd0,5'd0,5'd0, lo,lo, hi,5'd12,32'h102), "fifo2");
      runVec(mk(hi,5'd13,32'h103, hi,5'd22,32'hB2, lo,5'd0, 5'd0,5'd0,5'd0, lo,lo, hi,5'd13,32'h103), "fifo3");
      runVec(mk(lo,5'd0,32'd0,    hi,5'd22,32'hB2, lo,5'd0, 5'd0,5'd0,5'd0, lo,lo, hi,5'd20,32'hB0),  "fifo4");
      runVec(mk(lo,5'd0,32'd0,    hi,5'd22,32'hB2, lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, hi,5'd21,32'hB1),  "fifo5");
      runVec(mk(lo,5'd0,32'd0,    lo,5'd0,32'd0,   lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, hi,5'd22,32'hB2),  "fifo6");
      runVec(mk(lo,5'd0,32'd0,    lo,5'd0,32'd0,   lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0),    "fifo7");

`ifdef DEBUG_PORT_EN
      // Debug starved by the ALU, then aged past the FIFO; held request acked
      // once; a second request wins after 8 denied cycles against a refilled FIFO.
      for (int n = 0; n <= 24; n++) begin
         ldIdx = (n <= 1) ? n : ((n <= 12) ? 2 : n - 10);
         v = mk((n <= 9) ? hi : lo, 5'd14, 32'h200 + 32'(n),
                (n <= 21) ? hi : lo, 5'd25, 32'hC0 + 32'(ldIdx),
                lo, 5'd0, 5'd0, 5'd0, 5'd0, lo,
                ((n <= 1) || ((n >= 12) && (n <= 21)) || (n >= 23)) ? hi : lo,
                lo, 5'd0, 32'd0);
         v.dbgReq  = ((n <= 11) || ((n >= 13) && (n <= 21))) ? hi : lo;
         v.dbgAddr = (n <= 11) ? 5'd6 : 5'd8;
         v.dbgData = (n <= 11) ? 32'h66 : 32'h88;
         if (n <= 9) begin
            v.expWe = hi; v.expAddr = 5'd14; v.expData = 32'h200 + 32'(n);
         end else if (n == 10) begin
            v.expWe = hi; v.expAddr = 5'd6;  v.expData = 32'h66; v.expAck = hi;
         end else if (n <= 20) begin
            v.expWe = hi; v.expAddr = 5'd25; v.expData = 32'hC0 + 32'(n - 11);
         end else if (n == 21) begin
            v.expWe = hi; v.expAddr = 5'd8;  v.expData = 32'h88; v.expAck = hi;
         end else if (n <= 23) begin
            v.expWe = hi; v.expAddr = 5'd25; v.expData = 32'hC0 + 32'(n - 12);
         end
         runVec(v, $sformatf("dbg%0d", n));
      end
`else
      // Debug port absent: a held request never writes or acks
      for (int n = 0; n < 4; n++) begin
         v = mk(lo,5'd0,32'd0, lo,5'd0,32'd0, lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0);
         v.dbgReq  = hi;
         v.dbgAddr = 5'd6;
         v.dbgData = 32'h66;
         runVec(v, $sformatf("nodbg%0d", n));
      end
`endif

      // Reset in the middle of activity: two buffered loads and busy[3]
      runVec(mk(lo,5'd0,32'd0, lo,5'd0,32'd0,   hi,5'd3, 5'd0,5'd0,5'd0, lo,hi, lo,5'd0,32'd0), "rst0");
      runVec(mk(hi,5'd1,32'h1, hi,5'd12,32'hC,  lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, hi,5'd1,32'h1),  "rst1");
      runVec(mk(hi,5'd2,32'h2, hi,5'd13,32'hD,  lo,5'd0, 5'd0,5'd0,5'd0, lo,hi, hi,5'd2,32'h2),  "rst2");
      applyStimulus(mk(hi,5'd5,32'h5, hi,5'd14,32'hE, lo,5'd0, 5'd3,5'd0,5'd0, hi,lo, lo,5'd0,32'd0));
      #1;
      checkOutput("rst3 stall",    {31'd0, stall},    32'd1);
      checkOutput("rst3 ld_ready", {31'd0, ld_ready}, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("midrst rf_we",    {31'd0, rf_we},    32'd0);
      checkOutput("midrst rf_waddr", {27'd0, rf_waddr}, 32'd0);
      checkOutput("midrst rf_wdata", rf_wdata,          32'd0);
      checkOutput("midrst dbg_ack",  {31'd0, dbg_ack},  32'd0);
      checkOutput("midrst ld_ready", {31'd0, ld_ready}, 32'd0);
      checkOutput("midrst stall",    {31'd0, stall},    32'd0);
      @(posedge clk);
      #1;
      checkOutput("midrst2 rf_we",    {31'd0, rf_we},    32'd0);
      checkOutput("midrst2 ld_ready", {31'd0, ld_ready}, 32'd0);
      rst = 1'b1;
      runVec(mk(lo,5'd0,32'd0, lo,5'd0,32'd0, lo,5'd0, 5'd3,5'd0,5'd0, lo,hi, lo,5'd0,32'd0), "post0");
      runVec(mk(lo,5'd0,32'd0, lo,5'd0,32'd0, lo,5'd0, 5'd3,5'd0,5'd0, lo,hi, lo,5'd0,32'd0), "post1");

      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
